// File: rtl/timing_sequencer.sv
// Sequence counter, T-step decoder and latched opcode decoder for the MBC processor.
// Ends each instruction at its last step and owns the HLT / restart state.
module timing_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir_odat,
    input  logic        start,
    input  logic        sc_clr,
    output logic [15:0] dec_signal,
    output logic [7:0]  dec,
    output logic        ind,
    output logic [3:0]  sc_odat,
    output logic        instr_done,
    output logic        halted
);

    logic [3:0] sc_q, sc_d;
    logic       h_q, h_d;
    logic [7:0] dec_q, dec_d;
    logic       ind_q, ind_d;

    logic [3:0] end_step;
    logic       at_end;
    logic       hlt_cond;

    // Register-ref / I-O instructions finish at T7, memory-ref at T11.
    assign end_step = dec_q[7] ? 4'd7 : 4'd11;
    assign at_end   = (sc_q == end_step);
    assign hlt_cond = (sc_q == 4'd6) && dec_q[7] && !ind_q && ir_odat[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q  <= 4'd0;
            h_q   <= 1'b0;
            dec_q <= 8'h00;
            ind_q <= 1'b0;
        end else begin
            sc_q  <= sc_d;
            h_q   <= h_d;
            dec_q <= dec_d;
            ind_q <= ind_d;
        end
    end

    // Next-state logic; halt outranks sc_clr, which outranks HLT and end-of-instruction.
    always_comb begin
        sc_d  = sc_q + 4'd1;
        h_d   = h_q;
        dec_d = dec_q;
        ind_d = ind_q;
        if (h_q) begin
            sc_d = 4'd0;
            if (start) begin
                h_d = 1'b0;
            end
        end else if (sc_clr) begin
            sc_d = 4'd0;
        end else if (hlt_cond) begin
            sc_d = 4'd0;
            h_d  = 1'b1;
        end else if (at_end) begin
            sc_d = 4'd0;
        end

        if (sc_q == 4'd3) begin
            dec_d = 8'h01 << ir_odat[14:12];
            ind_d = ir_odat[15];
        end
    end

    // Moore outputs: registered state only
    always_comb begin
        dec_signal = h_q ? 16'h0000 : (16'h0001 << sc_q);
        instr_done = at_end && !h_q;
        halted     = h_q;
        sc_odat    = sc_q;
        dec        = dec_q;
        ind        = ind_q;
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: register-ref, memory-ref, HLT/restart,
// simultaneous sc_clr/HLT, and reset mid-instruction.
module tb_timing_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] ir_odat;
    logic        start;
    logic        sc_clr;
    logic [15:0] dec_signal;
    logic [7:0]  dec;
    logic        ind;
    logic [3:0]  sc_odat;
    logic        instr_done;
    logic        halted;

    int vec_cnt = 0;
    int err_cnt = 0;

    timing_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .ir_odat    (ir_odat),
        .start      (start),
        .sc_clr     (sc_clr),
        .dec_signal (dec_signal),
        .dec        (dec),
        .ind        (ind),
        .sc_odat    (sc_odat),
        .instr_done (instr_done),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dec_signal must be one-hot or zero at every falling edge once out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            vec_cnt++;
            if (!$onehot0(dec_signal)) begin
                err_cnt++;
                $display("FAIL onehot0 dec_signal=%h", dec_signal);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sc_clr = 1'b0; ir_odat = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        vec_cnt++;
        if (dec_signal !== 16'h0001 || dec !== 8'h00 || ind !== 1'b0 || sc_odat !== 4'd0
            || instr_done !== 1'b0 || halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset sig=%h dec=%h ind=%b sc=%0d done=%b halt=%b exp sig=0001 rest 0",
                     dec_signal, dec, ind, sc_odat, instr_done, halted);
        end
    endtask

    task automatic test_regref();
        logic [15:0] exp_sig;
        logic [7:0]  exp_dec;
        ir_odat = 16'h7800;
        for (int k = 0; k < 16; k++) begin
            exp_sig = 16'h0001 << (k % 8);
            exp_dec = (k >= 4) ? 8'h80 : 8'h00;
            vec_cnt++;
            if (dec_signal !== exp_sig || dec !== exp_dec || instr_done !== ((k % 8) == 7)) begin
                err_cnt++;
                $display("FAIL regref k=%0d sig=%h exp %h dec=%h exp %h done=%b",
                         k, dec_signal, exp_sig, dec, exp_dec, instr_done);
            end
            tick();
        end
        vec_cnt++;
        if (sc_odat !== 4'd0) begin
            err_cnt++;
            $display("FAIL regref_wrap sc=%0d exp 0", sc_odat);
        end
    endtask

    task automatic test_memref();
        logic [15:0] exp_sig;
        ir_odat = 16'hA035;
        for (int c = 0; c < 12; c++) begin
            exp_sig = 16'h0001 << c;
            vec_cnt++;
            if (dec_signal !== exp_sig || instr_done !== (c == 11)
                || dec !== ((c >= 4) ? 8'h04 : 8'h80) || ind !== (c >= 4)) begin
                err_cnt++;
                $display("FAIL memref c=%0d sig=%h exp %h dec=%h ind=%b done=%b",
                         c, dec_signal, exp_sig, dec, ind, instr_done);
            end
            tick();
        end
        vec_cnt++;
        if (sc_odat !== 4'd0 || dec_signal !== 16'h0001) begin
            err_cnt++;
            $display("FAIL memref_end sc=%0d sig=%h exp 0 / 0001", sc_odat, dec_signal);
        end
    endtask

    task automatic test_hlt_restart();
        logic [15:0] exp_sig;
        ir_odat = 16'h7001;
        for (int c = 0; c < 6; c++) tick();
        vec_cnt++;
        if (dec_signal !== 16'h0040 || halted !== 1'b0 || dec !== 8'h80 || ind !== 1'b0) begin
            err_cnt++;
            $display("FAIL hlt_t6 sig=%h halt=%b dec=%h ind=%b exp 0040 0 80 0",
                     dec_signal, halted, dec, ind);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            sc_clr = (i >= 5 && i < 8);
            vec_cnt++;
            if (halted !== 1'b1 || dec_signal !== 16'h0000 || sc_odat !== 4'd0 || instr_done !== 1'b0) begin
                err_cnt++;
                $display("FAIL halted i=%0d halt=%b sig=%h sc=%0d done=%b exp 1 0000 0 0",
                         i, halted, dec_signal, sc_odat, instr_done);
            end
            tick();
        end
        sc_clr = 1'b0;
        ir_odat = 16'h7800;
        start = 1'b1;
        tick();
        start = 1'b0;
        vec_cnt++;
        if (halted !== 1'b0 || dec_signal !== 16'h0001) begin
            err_cnt++;
            $display("FAIL restart halt=%b sig=%h exp 0 0001", halted, dec_signal);
        end
        // start while running must not disturb the step sequence
        for (int c = 0; c < 8; c++) begin
            exp_sig = 16'h0001 << c;
            start = (c == 2 || c == 5);
            vec_cnt++;
            if (dec_signal !== exp_sig || halted !== 1'b0) begin
                err_cnt++;
                $display("FAIL run_start c=%0d sig=%h exp %h halt=%b", c, dec_signal, exp_sig, halted);
            end
            tick();
        end
        start = 1'b0;
        vec_cnt++;
        if (dec_signal !== 16'h0001) begin
            err_cnt++;
            $display("FAIL run_start_end sig=%h exp 0001", dec_signal);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp_sig;
        ir_odat = 16'h7001;
        for (int c = 0; c < 6; c++) tick();
        sc_clr = 1'b1;
        tick();
        sc_clr = 1'b0;
        vec_cnt++;
        if (sc_odat !== 4'd0 || halted !== 1'b0 || dec_signal !== 16'h0001) begin
            err_cnt++;
            $display("FAIL clr_vs_hlt sc=%0d halt=%b sig=%h exp 0 0 0001", sc_odat, halted, dec_signal);
        end
        ir_odat = 16'h2010;
        for (int c = 0; c < 9; c++) tick();
        vec_cnt++;
        if (sc_odat !== 4'd9 || dec !== 8'h04 || ind !== 1'b0) begin
            err_cnt++;
            $display("FAIL pre_clr9 sc=%0d dec=%h ind=%b exp 9 04 0", sc_odat, dec, ind);
        end
        sc_clr = 1'b1;
        ir_odat = 16'h7800;
        tick();
        sc_clr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            exp_sig = 16'h0001 << c;
            vec_cnt++;
            if (dec_signal !== exp_sig || dec !== ((c >= 4) ? 8'h80 : 8'h04) || instr_done !== (c == 7)) begin
                err_cnt++;
                $display("FAIL clr9 c=%0d sig=%h exp %h dec=%h done=%b", c, dec_signal, exp_sig, dec, instr_done);
            end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        ir_odat = 16'hA035;
        for (int c = 0; c < 9; c++) tick();
        vec_cnt++;
        if (sc_odat !== 4'd9 || dec !== 8'h04 || ind !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_rst9 sc=%0d dec=%h ind=%b exp 9 04 1", sc_odat, dec, ind);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec_cnt++;
        if (sc_odat !== 4'd0 || dec !== 8'h00 || ind !== 1'b0 || dec_signal !== 16'h0001 || halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_midop sc=%0d dec=%h ind=%b sig=%h halt=%b exp 0 00 0 0001 0",
                     sc_odat, dec, ind, dec_signal, halted);
        end
        // DEC is zero after reset, so the first instruction runs to T11 unless captured otherwise
        ir_odat = 16'h7800;
        for (int c = 0; c < 8; c++) tick();
        vec_cnt++;
        if (dec_signal !== 16'h0001 || dec !== 8'h80) begin
            err_cnt++;
            $display("FAIL post_rst_regref sig=%h dec=%h exp 0001 80", dec_signal, dec);
        end
    endtask

    initial begin
        test_reset();
        test_regref();
        test_memref();
        test_hlt_restart();
        test_simultaneous();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
